// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter.
// Enables one oscillator and lets it settle, then counts its synchronized rising edges over a
// programmable window of ro_clk cycles. The result and a saturation flag are published with a
// one-cycle done pulse.
//
// Ports:
//   ro_clk      block clock, all state on its rising edge
//   ro_rst_n    asynchronous active-low reset
//   ro_ce_n     active-low start strobe; ro_sel and ro_win are sampled with it
//   ro_sel      channel to measure
//   ro_win      window length in ro_clk cycles
//   ro_osc_i    oscillator outputs, asynchronous to ro_clk
//   ro_en       one-hot oscillator enable (registered)
//   ro_busy     high whenever a measurement is in progress
//   ro_done     one-cycle completion pulse
//   ro_ovf      the last result saturated
//   ro_count_q  last measured edge count
module ro_freq_meter #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned WIN_W      = 12,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              ro_clk,
  input  logic              ro_rst_n,
  input  logic              ro_ce_n,
  input  logic [SEL_W-1:0]  ro_sel,
  input  logic [WIN_W-1:0]  ro_win,
  input  logic [NUM_CH-1:0] ro_osc_i,
  output logic [NUM_CH-1:0] ro_en,
  output logic              ro_busy,
  output logic              ro_done,
  output logic              ro_ovf,
  output logic [CNT_W-1:0]  ro_count_q
);

  // One timer serves both the settle phase and the count window.
  localparam int unsigned SetW = $clog2(SETTLE_CYC);
  localparam int unsigned TmrW = (WIN_W > SetW) ? WIN_W : SetW;
  localparam logic [TmrW-1:0] SettleLast = TmrW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StCount, StDone} state_e;

  state_e            state_q;
  logic [TmrW-1:0]   tmr_q;
  logic [WIN_W-1:0]  win_q;
  logic [NUM_CH-1:0] en_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cnt_ovf_q;
  logic              done_q;
  logic              ovf_q;
  logic [CNT_W-1:0]  count_q;

  logic [NUM_CH-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] sel_onehot;
  logic              sel_ok;
  logic              sel_edge;
  logic [TmrW-1:0]   win_last;

  // Two-flop synchronizer plus one history flop for rising-edge detection.
  always_ff @(posedge ro_clk or negedge ro_rst_n) begin
    if (!ro_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= ro_osc_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

  always_comb begin
    sel_onehot = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sel_onehot[i] = (32'(ro_sel) == i);
    end
  end

  assign sel_ok   = (32'(ro_sel) < NUM_CH);
  // en_q holds the latched channel as one-hot, so it doubles as the edge mux.
  assign sel_edge = |(rise & en_q);
  assign win_last = TmrW'(win_q) - TmrW'(1);

  always_ff @(posedge ro_clk or negedge ro_rst_n) begin
    if (!ro_rst_n) begin
      state_q   <= StIdle;
      tmr_q     <= '0;
      win_q     <= '0;
      en_q      <= '0;
      cnt_q     <= '0;
      cnt_ovf_q <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!ro_ce_n && sel_ok) begin
            state_q   <= StSettle;
            tmr_q     <= '0;
            win_q     <= ro_win;
            en_q      <= sel_onehot;
            cnt_q     <= '0;
            cnt_ovf_q <= 1'b0;
          end
        end
        StSettle: begin
          if (tmr_q == SettleLast) begin
            tmr_q     <= '0;
            cnt_q     <= '0;
            cnt_ovf_q <= 1'b0;
            if (win_q == '0) begin
              state_q <= StDone;
              en_q    <= '0;
            end else begin
              state_q <= StCount;
            end
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end
        StCount: begin
          if (sel_edge) begin
            // Saturate rather than wrap; remember that an edge was lost.
            if (&cnt_q) begin
              cnt_ovf_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          if (tmr_q == win_last) begin
            state_q <= StDone;
            en_q    <= '0;
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b1;
          count_q <= cnt_q;
          ovf_q   <= cnt_ovf_q;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ro_en      = en_q;
  assign ro_busy    = (state_q != StIdle);
  assign ro_done    = done_q;
  assign ro_ovf     = ovf_q;
  assign ro_count_q = count_q;

endmodule

// File: doc/ro_freq_meter.md
RO_FREQ_METER -- requirements
Module: ro_freq_meter

Interface
REQ-001 Parameter NUM_CH, default 4: number of ring-oscillator channels, legal range 1..16.
REQ-002 Parameter CNT_W, default 16: edge-counter and result width.
REQ-003 Parameter WIN_W, default 12: measurement-window length width, in ro_clk cycles.
REQ-004 Parameter SETTLE_CYC, default 4: oscillator start-up and synchronizer flush cycles, at least 3.
REQ-005 Parameter SEL_W, default $clog2(NUM_CH) with a minimum of 1: channel-select width.
REQ-006 ro_clk  input  1  single block clock; all state on its rising edge.
REQ-007 ro_rst_n  input  1  asynchronous, active-low reset.
REQ-008 ro_ce_n  input  1  active-low start strobe; also qualifies sampling of ro_sel and ro_win.
REQ-009 ro_sel  input  SEL_W  channel to measure.
REQ-010 ro_win  input  WIN_W  window length in ro_clk cycles.
REQ-011 ro_osc_i  input  NUM_CH  oscillator outputs, asynchronous to ro_clk.
REQ-012 ro_en  output  NUM_CH  one-hot oscillator enable, registered.
REQ-013 ro_busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 ro_done  output  1  one-cycle completion pulse.
REQ-015 ro_ovf  output  1  counter saturation flag for the last result.
REQ-016 ro_count_q  output  CNT_W  last measured edge count.

Function
REQ-017 FSM states SHALL be IDLE, SETTLE, COUNT and DONE.
- IDLE->SETTLE: on ro_ce_n=0 with ro_sel<NUM_CH.
- SETTLE->COUNT: after exactly SETTLE_CYC cycles.
- COUNT->DONE: after exactly the latched window length in cycles.
- DONE->IDLE: unconditionally, after 1 cycle.
REQ-018 Acceptance of a start SHALL latch ro_sel and ro_win; later changes to either input SHALL NOT affect the measurement in progress.
REQ-019 Start with ro_sel>=NUM_CH SHALL be ignored: the FSM stays in IDLE with no ro_done and no output change.
REQ-020 ro_ce_n=0 outside IDLE SHALL be ignored, including during the DONE cycle.
REQ-021 ro_en[sel] SHALL be 1 during SETTLE and COUNT; all other ro_en bits SHALL be 0 at all times, and all bits SHALL be 0 in IDLE and DONE.
REQ-022 Each ro_osc_i bit SHALL pass through a 2-flop synchronizer; a rising edge SHALL be detected as synchronized bit 1 with the prior sample 0.
REQ-023 The edge counter SHALL clear on entry to COUNT and increment once per detected edge of the selected channel during COUNT.
REQ-024 Edges in SETTLE SHALL NOT be counted.
REQ-025 The count SHALL saturate at 2^CNT_W-1; any further edge SHALL set the internal overflow bit and SHALL NOT wrap the count.
REQ-026 In DONE, ro_count_q and ro_ovf SHALL load the counter and overflow bit, and ro_done SHALL be 1 for that cycle only.
REQ-027 ro_count_q and ro_ovf SHALL hold their values until the next DONE.
REQ-028 A latched ro_win=0 SHALL skip COUNT (SETTLE->DONE) and yield count 0 with ro_ovf=0.
REQ-029 Latency from the start-sampling edge to ro_done high SHALL be SETTLE_CYC+win+1 cycles.
REQ-030 Accuracy is specified only for oscillator frequencies below f(ro_clk)/2; result tolerance is ±1 edge.

Reset
REQ-031 ro_rst_n=0 SHALL immediately force IDLE, with ro_en=0, ro_busy=0, ro_done=0, ro_ovf=0, ro_count_q=0, and counter and synchronizer flops cleared, regardless of ro_clk.
REQ-032 Reset asserted mid-measurement SHALL abort without ro_done; after release the block SHALL accept a new start on the first edge with ro_ce_n=0.

Verification
REQ-033 Reset check: ro_clk 10 ns; ro_osc_i[1] toggling every 20 ns; ro_ce_n=0 with sel=1, win=100 -> ro_en=4'b0010 for 104 cycles, ro_done at cycle 105, ro_count_q=25±1, ro_ovf=0.
REQ-034 CNT_W=4, sel=0 with a 40 ns period, win=200 -> ro_count_q=15, ro_ovf=1; the next run with win=20 -> ro_count_q=5±1, ro_ovf=0.
REQ-035 Start with sel=NUM_CH -> ro_busy stays 0 and no ro_done; ro_ce_n pulses and ro_sel/ro_win changes while busy -> result unchanged, exactly one ro_done.
REQ-036 win=0 -> ro_done exactly SETTLE_CYC+1 cycles after start, ro_count_q=0; NUM_CH=1 build passes the same test.
REQ-037 ro_rst_n pulsed low between clock edges mid-COUNT -> all outputs go to 0 before the next edge, no ro_done; a fresh start afterwards completes normally.
